// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths, FSM state and entry layout for the MEM/WB stage register.
package mem_wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [DATA_W_DEF-1:0] readdata;
        logic [DATA_W_DEF-1:0] aluresult;
        logic [REG_AW_DEF-1:0] writereg;
    } entry_t;
endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// mem_wb_pipe_reg_if: upstream and write-back handshake bundle; slave is the stage register's view.
interface mem_wb_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_regwrite;
    logic              in_memtoreg;
    logic [DATA_W-1:0] in_readdata;
    logic [DATA_W-1:0] in_aluresult;
    logic [REG_AW-1:0] in_writereg;
    logic              out_valid;
    logic              out_ready;
    logic              out_regwrite;
    logic              out_memtoreg;
    logic [DATA_W-1:0] out_readdata;
    logic [DATA_W-1:0] out_aluresult;
    logic [REG_AW-1:0] out_writereg;
    logic [DATA_W-1:0] out_wbdata;
    modport slave (
        input  in_valid, in_regwrite, in_memtoreg, in_readdata, in_aluresult, in_writereg, out_ready,
        output in_ready, out_valid, out_regwrite, out_memtoreg, out_readdata, out_aluresult,
               out_writereg, out_wbdata
    );
    modport master (
        output in_valid, in_regwrite, in_memtoreg, in_readdata, in_aluresult, in_writereg, out_ready,
        input  in_ready, out_valid, out_regwrite, out_memtoreg, out_readdata, out_aluresult,
               out_writereg, out_wbdata
    );
endinterface

// File: rtl/mem_wb_slot.sv
// mem_wb_slot: one entry register; payload survives unload so outputs hold, clear zeroes everything.
module mem_wb_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            if (load) q <= d;
            valid <= load | (valid & ~unload);
        end
    end
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB stage register with valid/ready handshake, flush and write-back mux.
// Define MEM_WB_SKID_EN for the registered-ready build with a one-entry skid slot.
module mem_wb_pipe_reg
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input logic              clk,
    input logic              reset,
    input logic              flush,
    mem_wb_pipe_reg_if.slave bus
);
    localparam int W = 2 + 2 * DATA_W + REG_AW;
    logic [W-1:0]      in_e, main_d, main_q;
    logic              main_v, main_ld, in_xfer, out_xfer;
    logic              m_rw, m_mtr;
    logic [DATA_W-1:0] m_rd, m_alu;
    logic [REG_AW-1:0] m_wr;
    // Register 0 is never written, so its regwrite is dropped on entry.
    assign in_e = {bus.in_regwrite & (bus.in_writereg != '0), bus.in_memtoreg,
                   bus.in_readdata, bus.in_aluresult, bus.in_writereg};
    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = main_v & bus.out_ready;
    mem_wb_slot #(.W(W)) u_main (
        .clk(clk), .reset(reset), .clear(flush), .load(main_ld), .unload(out_xfer),
        .d(main_d), .q(main_q), .valid(main_v)
    );
`ifdef MEM_WB_SKID_EN
    localparam logic [1:0] S_EMPTY = EMPTY, S_FULL = FULL, S_SKID = SKID;
    logic [W-1:0] skid_q;
    logic         skid_v, skid_ld, ready_q;
    logic [1:0]   state, next_state;
    assign state = skid_v ? S_SKID : main_v ? S_FULL : S_EMPTY;
    always_comb begin
        next_state = state;
        if (flush) next_state = S_EMPTY;
        else if (state == S_EMPTY) next_state = in_xfer ? S_FULL : S_EMPTY;
        else if (state == S_FULL) next_state = (in_xfer == out_xfer) ? S_FULL : in_xfer ? S_SKID : S_EMPTY;
        else next_state = out_xfer ? S_FULL : S_SKID;
    end
    assign skid_ld = in_xfer & main_v & ~out_xfer;
    assign main_ld = out_xfer ? (in_xfer | skid_v) : (in_xfer & ~main_v);
    assign main_d  = skid_v ? skid_q : in_e;
    mem_wb_slot #(.W(W)) u_skid (
        .clk(clk), .reset(reset), .clear(flush), .load(skid_ld), .unload(out_xfer),
        .d(in_e), .q(skid_q), .valid(skid_v)
    );
    // Ready is a flop so write-back stalls never form a combinational path upstream.
    always_ff @(posedge clk) ready_q <= !reset ? 1'b1 : (next_state != S_SKID);
    assign bus.in_ready = ready_q;
`else
    assign main_ld      = in_xfer;
    assign main_d       = in_e;
    assign bus.in_ready = reset & (bus.out_ready | ~main_v);
`endif
    assign {m_rw, m_mtr, m_rd, m_alu, m_wr} = main_q;
    assign bus.out_valid     = main_v;
    assign bus.out_regwrite  = m_rw & main_v;
    assign bus.out_memtoreg  = m_mtr;
    assign bus.out_readdata  = m_rd;
    assign bus.out_aluresult = m_alu;
    assign bus.out_writereg  = m_wr;
    assign bus.out_wbdata    = m_mtr ? m_rd : m_alu;
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: directed scenarios plus randomized traffic against a FIFO-occupancy model.
// Works for both builds; MEM_WB_SKID_EN selects capacity 2 with registered ready.
module tb_mem_wb_pipe_reg;
    import mem_wb_pkg::*;
    logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
    always #5 clk = ~clk;
    mem_wb_pipe_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();
    mem_wb_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
    int total = 0, bad = 0;
    entry_t mq[$];
    entry_t shown = '0;

    function automatic bit model_ready();
`ifdef MEM_WB_SKID_EN
        return mq.size() < 2;
`else
        return reset && (bus.out_ready || mq.size() == 0);
`endif
    endfunction

    task automatic drive(input bit v, input bit rw, input bit mtr, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr);
        bus.in_valid = v;
        bus.in_regwrite = rw;
        bus.in_memtoreg = mtr;
        bus.in_readdata = rd;
        bus.in_aluresult = alu;
        bus.in_writereg = wr;
    endtask

    // Advance one clock and update the model as a bounded queue of accepted entries.
    task automatic tick();
        bit acc_in, acc_out;
        entry_t e;
        @(posedge clk);
        acc_in = bus.in_valid && model_ready();
        acc_out = mq.size() != 0 && bus.out_ready;
        e.regwrite = bus.in_regwrite && bus.in_writereg != 5'd0;
        e.memtoreg = bus.in_memtoreg;
        e.readdata = bus.in_readdata;
        e.aluresult = bus.in_aluresult;
        e.writereg = bus.in_writereg;
        if (!reset || flush) begin
            mq.delete();
            shown = '0;
        end else begin
            if (acc_out) void'(mq.pop_front());
            if (acc_in) mq.push_back(e);
            if (mq.size() != 0) shown = mq[0];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        drive(1, 1, 0, 32'h1, 32'h2, 5'd3);
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
`ifdef MEM_WB_SKID_EN
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_low got %b want 1", bus.in_ready); end
`else
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got %b want 0", bus.in_ready); end
`endif
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rel got %b want 1", bus.in_ready); end
        total++; if ({bus.out_regwrite, bus.out_memtoreg, bus.out_readdata, bus.out_aluresult, bus.out_writereg, bus.out_wbdata} !== '0) begin
            bad++; $display("FAIL reset_zero got %h want 0", {bus.out_readdata, bus.out_aluresult, bus.out_writereg, bus.out_wbdata});
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(1, 1, 0, 32'h0, 32'h0000_1234, 5'd5);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
        total++; if (bus.out_wbdata !== 32'h0000_1234) begin bad++; $display("FAIL basic_wbdata got %h want 00001234", bus.out_wbdata); end
        total++; if (bus.out_regwrite !== 1'b1) begin bad++; $display("FAIL basic_regwrite got %b want 1", bus.out_regwrite); end
        total++; if (bus.out_writereg !== 5'd5) begin bad++; $display("FAIL basic_writereg got %0d want 5", bus.out_writereg); end
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.out_regwrite !== 1'b0) begin bad++; $display("FAIL basic_drain got v=%b rw=%b want 0 0", bus.out_valid, bus.out_regwrite); end
        total++; if (bus.out_wbdata !== 32'h0000_1234) begin bad++; $display("FAIL basic_hold got %h want 00001234", bus.out_wbdata); end
    endtask

    task automatic test_reg0();
        bus.out_ready = 1'b1;
        drive(1, 1, 0, 32'h0, 32'h77, 5'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL reg0_valid got %b want 1", bus.out_valid); end
        total++; if (bus.out_regwrite !== 1'b0) begin bad++; $display("FAIL reg0_regwrite got %b want 0", bus.out_regwrite); end
        total++; if (bus.out_writereg !== 5'd0) begin bad++; $display("FAIL reg0_writereg got %0d want 0", bus.out_writereg); end
        tick();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        drive(1, 1, 0, 32'h0, 32'hAAAA_0001, 5'd1);
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_aluresult !== 32'hAAAA_0001) begin bad++; $display("FAIL stall_a got v=%b alu=%h want 1 aaaa0001", bus.out_valid, bus.out_aluresult); end
        drive(1, 1, 0, 32'h0, 32'hBBBB_0002, 5'd2);
`ifdef MEM_WB_SKID_EN
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_b got %b want 1", bus.in_ready); end
`else
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_b got %b want 0", bus.in_ready); end
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_full_ready got %b want 0", bus.in_ready); end
        total++; if (bus.out_aluresult !== 32'hAAAA_0001) begin bad++; $display("FAIL stall_hold1 got %h want aaaa0001", bus.out_aluresult); end
        tick();
        total++; if (bus.out_aluresult !== 32'hAAAA_0001 || bus.out_writereg !== 5'd1) begin bad++; $display("FAIL stall_hold2 got %h/%0d want aaaa0001/1", bus.out_aluresult, bus.out_writereg); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
`ifdef MEM_WB_SKID_EN
        total++; if (bus.out_valid !== 1'b1 || bus.out_aluresult !== 32'hBBBB_0002) begin bad++; $display("FAIL stall_b_out got v=%b alu=%h want 1 bbbb0002", bus.out_valid, bus.out_aluresult); end
        tick();
`else
        total++; if (bus.out_valid !== 1'b0 || bus.out_aluresult !== 32'hAAAA_0001) begin bad++; $display("FAIL stall_b_out got v=%b alu=%h want 0 aaaa0001", bus.out_valid, bus.out_aluresult); end
`endif
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1, 1, 1, 32'h1111_1111, 32'h11, 5'd9);
        tick();
        drive(1, 1, 0, 32'h2222_2222, 32'h22, 5'd10);
        tick();
        drive(1, 1, 0, 32'h3333_3333, 32'h33, 5'd11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.out_valid !== 1'b0 || bus.out_regwrite !== 1'b0) begin bad++; $display("FAIL flush_valid got v=%b rw=%b want 0 0", bus.out_valid, bus.out_regwrite); end
        total++; if ({bus.out_memtoreg, bus.out_readdata, bus.out_aluresult, bus.out_writereg, bus.out_wbdata} !== '0) begin
            bad++; $display("FAIL flush_zero got %h %h %h %h want 0", bus.out_readdata, bus.out_aluresult, bus.out_writereg, bus.out_wbdata);
        end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_memload();
        bus.out_ready = 1'b0;
        drive(1, 1, 1, 32'hDEAD_BEEF, 32'h4, 5'd7);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.out_wbdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mem_wbdata got %h want deadbeef", bus.out_wbdata); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_wbdata !== 32'hDEAD_BEEF || bus.out_aluresult !== 32'h4) begin
                bad++; $display("FAIL mem_stall%0d got v=%b wb=%h alu=%h want 1 deadbeef 4", i, bus.out_valid, bus.out_wbdata, bus.out_aluresult);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mem_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [104:0] got, want;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) >= 2);
            flush = ($urandom_range(0, 99) < 4);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                  $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)));
            tick();
            got = {bus.out_valid, bus.in_ready, bus.out_regwrite, bus.out_memtoreg, bus.out_readdata,
                   bus.out_aluresult, bus.out_writereg, bus.out_wbdata};
            want = {mq.size() != 0, model_ready(), shown.regwrite && mq.size() != 0, shown.memtoreg,
                    shown.readdata, shown.aluresult, shown.writereg,
                    shown.memtoreg ? shown.readdata : shown.aluresult};
            total++; if (got !== want) begin bad++; $display("FAIL rand cyc=%0d got %h want %h", c, got, want); end
        end
        reset = 1'b1;
        flush = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_reg0();
        test_stall();
        test_flush();
        test_memload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe_reg.md
# mem_wb_pipe_reg

Parametrised MEM/WB pipeline register with a valid/ready handshake, flush, and an optional one-entry skid buffer, placed between the data-memory stage and register-file write-back. It supersedes the fixed-width, always-advancing stage register. It lets write-back stall without combinational ready paths, and it suppresses writes to register 0 at the stage boundary. Write-back data (ALU result or memory load) is selected inside the block.

## Interface
Parameters:
- DATA_W, 32, width of read data, ALU result and write-back data
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  block can accept an entry this cycle
- in_regwrite, in_memtoreg  in  1 each  control bits
- in_readdata, in_aluresult  in  DATA_W each  payload
- in_writereg  in  REG_AW  destination register
- out_valid  out  1  entry present toward write-back
- out_ready  in  1  write-back consumes the entry this cycle
- out_regwrite, out_memtoreg  out  1 each
- out_readdata, out_aluresult  out  DATA_W each
- out_writereg  out  REG_AW
- out_wbdata  out  DATA_W  out_memtoreg ? out_readdata : out_aluresult

## Operation
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Stored regwrite = in_regwrite & (in_writereg != 0). Register 0 is never written.
- out_regwrite = stored regwrite & out_valid. Invalid entries never write.
- Payload outputs hold their last value when out_valid=0, except after reset or flush, when they are zero.
- State machine (skid build): EMPTY, FULL (main slot valid), SKID (main and skid valid).
  - EMPTY: input transfer -> FULL.
  - FULL: input without output -> SKID, entry stored in skid. Output without input -> EMPTY. Both -> FULL, main reloaded.
  - SKID: output transfer -> FULL, skid moves to main. No input is accepted in SKID.
- in_ready registered = (next state != SKID).
- flush: next state EMPTY, all outputs zero, any simultaneous input is dropped. Flush has priority over every transfer.
- Reset (reset=0): identical to flush. In addition, in_ready = 1 on the first cycle after reset deasserts.

## Timing
- Latency: 1 cycle from input transfer to out_valid when EMPTY or when FULL with a simultaneous output transfer.
- Skid entry appears on the outputs the cycle after the main entry transfers out.
- Reset values:
  - out_valid=0, out_regwrite=0, out_memtoreg=0
  - out_readdata, out_aluresult, out_writereg, out_wbdata all zero
  - in_ready=1 (skid build); 0 while reset is low (no-skid build)
- out_valid must not drop without an output transfer, flush, or reset.
- Payload is stable while out_valid=1 and out_ready=0.
- Reset or flush mid-stall discards both slots with no partial write-back.
- in_ready depends only on state, never on out_ready in the same cycle (skid build).

## Configuration
- MEM_WB_SKID_EN defined: skid slot and the three-state FSM described above; in_ready is a register.
- MEM_WB_SKID_EN undefined: single slot with states EMPTY/FULL only.
  - in_ready = reset & (out_ready | ~out_valid), combinational.
  - Same latency; throughput 1/cycle with out_ready tied high.

## Structure
- Shared package mem_wb_pkg holds:
  - DATA_W and REG_AW defaults
  - the state typedef (EMPTY, FULL, SKID)
  - a packed entry typedef {regwrite, memtoreg, readdata, aluresult, writereg}
- One sub-module, mem_wb_slot: a single entry register with load, clear and valid. Main and skid are each one instance.
- out_wbdata mux stays in the top.

## Test plan
- Reset low 2 cycles, then release -> out_valid=0, all outputs 0, in_ready=1 (skid).
- in_valid=1, in_aluresult=32'h0000_1234, in_writereg=5, in_regwrite=1, in_memtoreg=0, out_ready=1 -> next cycle out_valid=1, out_wbdata=32'h0000_1234, out_regwrite=1.
- in_writereg=0, in_regwrite=1 -> out_regwrite=0, out_writereg=0, out_valid=1.
- out_ready=0, push entries A then B (skid build) -> in_ready=0 after B. Outputs hold A. After out_ready=1, A leaves, then B appears next cycle, then in_ready=1.
- State SKID, flush=1 with in_valid=1 -> next cycle out_valid=0, all outputs 0, state EMPTY, and the flushed input never appears.
- in_memtoreg=1, in_readdata=32'hDEAD_BEEF, in_aluresult=32'h4 -> out_wbdata=32'hDEAD_BEEF. Holds across 3 stall cycles with out_ready=0.
